jtag_debug_cmd_queue: RTL and testbench

Parametrised system-clock side of the Nios II JTAG debug module. It takes the scan register, IR and virtual-state strobes from the TCK domain and synchronises them into `clk`. It queues each completed DR update as a command in a small FIFO and presents the commands through a valid/ready handshake with per-channel action pulses. It replaces the fixed 38-bit / 2-bit-IR / unbuffered sysclk decoder. It adds variable widths, 2^IR_W channels, back-pressure, overrun detection and reset-safe edge arming.

---
 rtl/jtag_debug_cmd_queue.sv | 146 ++++++++++++++
 tb/tb_jtag_debug_cmd_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_queue.sv
// System-clock side of the JTAG debug bridge: synchronises the TCK-domain update strobes,
// queues each DR update as {ir, dr} and hands it out over valid/ready with per-channel pulses.
`timescale 1ns/1ps
module jtag_debug_cmd_queue #(
  parameter int DR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DR_W-1:0]          sr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic                     cmd_ready,
  input  logic                     clr_overrun,
  output logic                     cmd_valid,
  output logic [IR_W-1:0]          cmd_ch,
  output logic [DR_W-1:0]          cmd_data,
  output logic                     cmd_act,
  output logic [(2**IR_W)-1:0]     take_action,
  output logic [(2**IR_W)-1:0]     take_no_action,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun,
  output logic [IR_W-1:0]          ir_latched
);

  localparam int CH     = 2**IR_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = IR_W + DR_W;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic                   uir_hist_q, uir_hist_d;
  logic                   udr_hist_q, udr_hist_d;
  logic                   uir_arm_q, uir_arm_d;
  logic                   udr_arm_q, udr_arm_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [IR_W-1:0]        ir_q, ir_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [ENT_W-1:0]       mem_q [DEPTH];

  logic                   uir_s, udr_s, filled;
  logic                   uir_rise, udr_rise;
  logic                   pop, full, wr_en, drop;
  logic [ENT_W-1:0]       head;
  logic [CH-1:0]          ch_onehot;

  always_comb begin
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_s      = uir_sync_q[SYNC_STAGES-1];
    udr_s      = udr_sync_q[SYNC_STAGES-1];

    // The chains come out of reset full of zeros that say nothing about the real strobe
    // level, so arming waits until the chain has been refilled from the live inputs.
    filled     = (fill_q == FILL_W'(SYNC_STAGES));
    fill_d     = filled ? fill_q : fill_q + FILL_W'(1);
    uir_arm_d  = uir_arm_q | (filled & ~uir_s);
    udr_arm_d  = udr_arm_q | (filled & ~udr_s);
    uir_hist_d = uir_s;
    udr_hist_d = udr_s;
    uir_rise   = uir_s & ~uir_hist_q & uir_arm_q;
    udr_rise   = udr_s & ~udr_hist_q & udr_arm_q;

    ir_d       = uir_rise ? ir_in : ir_q;
  end

  always_comb begin
    cmd_valid = (count_q != '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = cmd_valid & cmd_ready;
    // A full queue still accepts the push when the head leaves in the same cycle.
    wr_en     = udr_rise & (~full | pop);
    drop      = udr_rise & full & ~pop;

    wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overrun_d = drop | (overrun_q & ~clr_overrun);

    head      = mem_q[rd_ptr_q];
    cmd_ch    = cmd_valid ? head[ENT_W-1:DR_W] : '0;
    cmd_data  = cmd_valid ? head[DR_W-1:0]     : '0;
    cmd_act   = cmd_data[DR_W-1];

    ch_onehot      = CH'(1) << cmd_ch;
    take_action    = (pop &  cmd_act) ? ch_onehot : '0;
    take_no_action = (pop & ~cmd_act) ? ch_onehot : '0;

    fifo_level = count_q;
    overrun    = overrun_q;
    ir_latched = ir_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_hist_q <= 1'b0;
      udr_hist_q <= 1'b0;
      uir_arm_q  <= 1'b0;
      udr_arm_q  <= 1'b0;
      fill_q     <= '0;
      ir_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      uir_sync_q <= uir_sync_d;
      udr_sync_q <= udr_sync_d;
      uir_hist_q <= uir_hist_d;
      udr_hist_q <= udr_hist_d;
      uir_arm_q  <= uir_arm_d;
      udr_arm_q  <= udr_arm_d;
      fill_q     <= fill_d;
      ir_q       <= ir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: the storage array has no reset; an empty queue masks the head to zero, so stale
  // contents are never observable and the array can map onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ir_q, sr};
  end

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Directed bench for jtag_debug_cmd_queue at default parameters; each task owns one scenario
// and compares DUT outputs against hand-computed values.
`timescale 1ns/1ps
module tb_jtag_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_uir, vs_udr, cmd_ready, clr_overrun;
  logic        cmd_valid, cmd_act, overrun;
  logic [1:0]  cmd_ch, ir_latched;
  logic [37:0] cmd_data;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [37:0] vec [5];

  jtag_debug_cmd_queue #(.DR_W(38), .IR_W(2), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_ready(cmd_ready), .clr_overrun(clr_overrun), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_data(cmd_data), .cmd_act(cmd_act), .take_action(take_action),
    .take_no_action(take_no_action), .fifo_level(fifo_level), .overrun(overrun),
    .ir_latched(ir_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push lands on the third edge after the strobe goes high.
  task automatic udr_push(input logic [37:0] d);
    sr = d; vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; sr = '0; ir_in = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b1; clr_overrun = 1'b0;
    tick(2);
    n_cmp++;
    if ({cmd_valid, fifo_level, overrun, ir_latched, cmd_ch, cmd_data, cmd_act} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b level=%0d ovr=%b ir=%0d ch=%0d data=%h act=%b, want all 0",
               cmd_valid, fifo_level, overrun, ir_latched, cmd_ch, cmd_data, cmd_act);
    end
    n_cmp++;
    if ({take_action, take_no_action} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_pulses: ta=%b tna=%b, want 0", take_action, take_no_action);
    end
    reset = 1'b0; cmd_ready = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    ir_in = 2'd2; vs_uir = 1'b1;
    tick(2);
    n_cmp++;
    if (ir_latched !== 2'd0) begin
      n_err++; $display("FAIL basic_ir_early: got %0d want 0", ir_latched);
    end
    tick(1);
    n_cmp++;
    if (ir_latched !== 2'd2) begin
      n_err++; $display("FAIL basic_ir_latched: got %0d want 2", ir_latched);
    end
    vs_uir = 1'b0;
    tick(2);
    sr = 38'h20_0000_1234; cmd_ready = 1'b1; vs_udr = 1'b1;
    tick(2);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_valid_early: got %b want 0", cmd_valid);
    end
    tick(1);
    n_cmp++;
    if ({cmd_valid, cmd_ch, cmd_data, cmd_act} !== {1'b1, 2'd2, 38'h20_0000_1234, 1'b1}) begin
      n_err++;
      $display("FAIL basic_head: valid=%b ch=%0d data=%h act=%b want 1/2/2000001234/1",
               cmd_valid, cmd_ch, cmd_data, cmd_act);
    end
    n_cmp++;
    if ({take_action, take_no_action} !== {4'b0100, 4'b0000}) begin
      n_err++; $display("FAIL basic_pulse: ta=%b tna=%b want 0100/0000", take_action, take_no_action);
    end
    tick(1);
    n_cmp++;
    if ({cmd_valid, take_action} !== 5'b0) begin
      n_err++; $display("FAIL basic_one_cycle: valid=%b ta=%b want 0/0000", cmd_valid, take_action);
    end
    vs_udr = 1'b0;
    tick(2);
  endtask

  task automatic test_no_action();
    ir_in = 2'd1; vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(2);
    n_cmp++;
    if (ir_latched !== 2'd1) begin
      n_err++; $display("FAIL noact_ir: got %0d want 1", ir_latched);
    end
    sr = 38'h0_ABCD_EF12; vs_udr = 1'b1;
    tick(3);
    n_cmp++;
    if ({take_action, take_no_action, cmd_act} !== {4'b0000, 4'b0010, 1'b0}) begin
      n_err++;
      $display("FAIL noact_pulse: ta=%b tna=%b act=%b want 0000/0010/0", take_action, take_no_action, cmd_act);
    end
    tick(1);
    n_cmp++;
    if ({cmd_valid, take_no_action} !== 5'b0) begin
      n_err++; $display("FAIL noact_one_cycle: valid=%b tna=%b want 0/0000", cmd_valid, take_no_action);
    end
    vs_udr = 1'b0;
    tick(2);
  endtask

  task automatic test_overrun();
    vec[0] = 38'h20_1111_0000; vec[1] = 38'h00_2222_0001; vec[2] = 38'h3F_FFFF_FFFF;
    vec[3] = 38'h00_0000_0000; vec[4] = 38'h15_5555_5555;
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) udr_push(vec[i]);
    n_cmp++;
    if ({fifo_level, overrun} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL ovr_full: level=%0d ovr=%b want 4/0", fifo_level, overrun);
    end
    // Fifth update is dropped while clr_overrun is asserted on the same edge: set wins.
    sr = vec[4]; vs_udr = 1'b1;
    tick(2);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0; vs_udr = 1'b0;
    tick(1);
    n_cmp++;
    if ({fifo_level, overrun} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL ovr_drop: level=%0d ovr=%b want 4/1", fifo_level, overrun);
    end
    cmd_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({cmd_valid, cmd_ch, cmd_data} !== {1'b1, 2'd1, vec[i]}) begin
        n_err++;
        $display("FAIL ovr_drain_%0d: valid=%b ch=%0d data=%h want 1/1/%h", i, cmd_valid, cmd_ch, cmd_data, vec[i]);
      end
      n_cmp++;
      if ({take_action, take_no_action} !== (vec[i][37] ? {4'b0010, 4'b0000} : {4'b0000, 4'b0010})) begin
        n_err++; $display("FAIL ovr_pulse_%0d: ta=%b tna=%b act_bit=%b", i, take_action, take_no_action, vec[i][37]);
      end
      tick(1);
    end
    n_cmp++;
    if ({cmd_valid, fifo_level, overrun} !== {1'b0, 3'd0, 1'b1}) begin
      n_err++; $display("FAIL ovr_empty: valid=%b level=%0d ovr=%b want 0/0/1", cmd_valid, fifo_level, overrun);
    end
    cmd_ready = 1'b0; clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    vec[0] = 38'h21_0000_00A0; vec[1] = 38'h02_0000_00A1; vec[2] = 38'h23_0000_00A2;
    vec[3] = 38'h04_0000_00A3; vec[4] = 38'h25_0000_00A4;
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) udr_push(vec[i]);
    sr = vec[4]; vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0; cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_level, overrun} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL fpp_level: level=%0d ovr=%b want 4/0", fifo_level, overrun);
    end
    cmd_ready = 1'b1;
    #1;
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if ({cmd_valid, cmd_data} !== {1'b1, vec[i]}) begin
        n_err++; $display("FAIL fpp_drain_%0d: valid=%b data=%h want 1/%h", i, cmd_valid, cmd_data, vec[i]);
      end
      tick(1);
    end
    n_cmp++;
    if ({cmd_valid, fifo_level} !== 4'b0) begin
      n_err++; $display("FAIL fpp_empty: valid=%b level=%0d want 0/0", cmd_valid, fifo_level);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_arming();
    sr = 38'h26_0000_BEEF; vs_udr = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
    n_cmp++;
    if ({cmd_valid, fifo_level} !== 4'b0) begin
      n_err++; $display("FAIL arm_held_high: valid=%b level=%0d want 0/0", cmd_valid, fifo_level);
    end
    vs_udr = 1'b0;
    tick(4);
    vs_udr = 1'b1;
    tick(6);
    vs_udr = 1'b0;
    tick(3);
    n_cmp++;
    if ({fifo_level, cmd_data, cmd_ch} !== {3'd1, 38'h26_0000_BEEF, 2'd0}) begin
      n_err++;
      $display("FAIL arm_one_cmd: level=%0d data=%h ch=%0d want 1/260000beef/0", fifo_level, cmd_data, cmd_ch);
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_queue();
    cmd_ready = 1'b0;
    udr_push(38'h20_0000_0001);
    udr_push(38'h20_0000_0002);
    udr_push(38'h00_0000_0003);
    n_cmp++;
    if (fifo_level !== 3'd3) begin
      n_err++; $display("FAIL midq_level: got %0d want 3", fifo_level);
    end
    #2;
    reset = 1'b1;
    #1;
    cmd_ready = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_valid, fifo_level, take_action, take_no_action, cmd_data} !== '0) begin
      n_err++;
      $display("FAIL midq_reset: valid=%b level=%0d ta=%b tna=%b data=%h want all 0",
               cmd_valid, fifo_level, take_action, take_no_action, cmd_data);
    end
    tick(2);
    reset = 1'b0; cmd_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_action();
    test_overrun();
    test_full_push_pop();
    test_reset_arming();
    test_reset_mid_queue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
